// File: rtl/seq_detect_ctrl.sv
// -----------------------------------------------------------------------------
// seq_detect_ctrl
//
// Programmable serial-pattern detection controller. A loadable configuration
// (pattern, length, overlap mode) is held in registers. A start request arms a
// run over a fixed number of accepted din bits. Every occurrence of the pattern
// produces a registered one-cycle match pulse and bumps a saturating match
// counter. A normal end of frame gives a one-cycle done pulse.
//
// Ports
//   clk          : clock, all state changes on its rising edge
//   clr_n        : asynchronous active-low reset
//   cfg_we       : load cfg_pattern/cfg_len/cfg_overlap (IDLE only)
//   cfg_pattern  : pattern, first-received bit at cfg_pattern[cfg_len-1]
//   cfg_len      : pattern length, legal 1..PAT_MAX
//   cfg_overlap  : 1 = overlapping matches, 0 = flush history after a match
//   start        : request a run of frame_bits accepted bits
//   frame_bits   : frame length, sampled with start
//   abort        : terminate a run immediately (no done pulse)
//   din          : serial data bit
//   din_valid    : din is accepted on this edge while running
//   busy         : high while running
//   match        : one-cycle pulse per detected pattern
//   match_count  : matches in the current or last run (saturating)
//   sat          : sticky, set when an increment was attempted at the maximum
//   done         : one-cycle pulse at normal frame completion
//   err          : one-cycle pulse when start is rejected
// -----------------------------------------------------------------------------
module seq_detect_ctrl #(
  parameter  int PAT_MAX = 8,
  parameter  int CNT_W   = 8,
  parameter  int LEN_W   = 16,
  localparam int LW      = $clog2(PAT_MAX) + 1
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               start,
  input  logic [LEN_W-1:0]   frame_bits,
  input  logic               abort,
  input  logic               din,
  input  logic               din_valid,
  output logic               busy,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               sat,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // Configuration registers
  logic [PAT_MAX-1:0] pat_q;
  logic [LW-1:0]      len_q;
  logic               overlap_q;

  // Run datapath
  logic [PAT_MAX-1:0] hist;
  logic [LW-1:0]      fill;
  logic [LEN_W-1:0]   bit_cnt;
  logic [LEN_W-1:0]   frame_q;

  // Combinational helpers
  logic [LW-1:0]      len_eff;
  logic               start_ok;
  logic               start_bad;
  logic               accept;
  logic [PAT_MAX-1:0] hist_next;
  logic [LW-1:0]      fill_next;
  logic [LEN_W-1:0]   bit_cnt_next;
  logic [PAT_MAX-1:0] mask;
  logic               hit;
  logic               last;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // A start that coincides with a config load is validated against the
  // incoming length, since the load takes effect first.
  assign len_eff   = cfg_we ? cfg_len : len_q;
  assign start_ok  = (state == IDLE) && start && (len_eff != '0) &&
                     (len_eff <= LW'(PAT_MAX)) && (frame_bits != '0);
  assign start_bad = (state == IDLE) && start && !start_ok;

  // Abort wins over a simultaneous bit: that bit is simply never accepted.
  assign accept    = (state == RUN) && din_valid && !abort;

  assign hist_next    = {hist[PAT_MAX-2:0], din};
  assign fill_next    = (fill == LW'(PAT_MAX)) ? fill : fill + LW'(1);
  assign bit_cnt_next = bit_cnt + LEN_W'(1);
  assign last         = (bit_cnt_next == frame_q);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  // Match is judged on the post-shift history, so the completing bit itself
  // is part of the compared window.
  assign hit = (fill_next >= len_q) && ((hist_next & mask) == (pat_q & mask));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start_ok) state_next = RUN;
      RUN: begin
        if (abort)               state_next = IDLE;
        else if (accept && last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from state
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (state == RUN);
  end

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pat_q     <= PAT_MAX'(4'b1101);
      len_q     <= LW'(4);
      overlap_q <= 1'b1;
    end else if ((state == IDLE) && cfg_we) begin
      pat_q     <= cfg_pattern;
      len_q     <= cfg_len;
      overlap_q <= cfg_overlap;
    end
  end

  // ---------------------------------------------------------------------------
  // Run datapath and registered pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hist        <= '0;
      fill        <= '0;
      bit_cnt     <= '0;
      frame_q     <= '0;
      match_count <= '0;
      sat         <= 1'b0;
      match       <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      match <= accept && hit;
      done  <= accept && last;
      err   <= start_bad;

      if (start_ok) begin
        hist        <= '0;
        fill        <= '0;
        bit_cnt     <= '0;
        frame_q     <= frame_bits;
        match_count <= '0;
        sat         <= 1'b0;
      end else if (accept) begin
        hist    <= hist_next;
        bit_cnt <= bit_cnt_next;
        if (hit) begin
          // Non-overlapping mode forgets history so the next match needs a
          // fresh, complete pattern.
          fill <= overlap_q ? fill_next : '0;
          if (match_count == CNT_MAX) begin
            sat <= 1'b1;
          end else begin
            match_count <= match_count + CNT_W'(1);
          end
        end else begin
          fill <= fill_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_ctrl
//
// Directed testbench for seq_detect_ctrl. Two instances share every input: the
// default-parameter instance (dut) and a CNT_W=2 instance (dut_s) used for the
// counter saturation scenario. Inputs change 1 time unit after the rising edge
// and outputs are sampled there, i.e. away from the active edge.
// -----------------------------------------------------------------------------
module tb_seq_detect_ctrl;

  localparam int PAT_MAX = 8;
  localparam int LEN_W   = 16;
  localparam int LW      = $clog2(PAT_MAX) + 1;

  logic               clk;
  logic               clr_n;
  logic               cfg_we;
  logic [PAT_MAX-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;
  logic               cfg_overlap;
  logic               start;
  logic [LEN_W-1:0]   frame_bits;
  logic               abort;
  logic               din;
  logic               din_valid;

  logic       busy, match, sat, done, err;
  logic [7:0] match_count;
  logic       busy_s, match_s, sat_s, done_s, err_s;
  logic [1:0] match_count_s;

  int n_checks = 0;
  int n_fail   = 0;

  seq_detect_ctrl #(.PAT_MAX(PAT_MAX), .CNT_W(8), .LEN_W(LEN_W)) dut (
    .clk(clk), .clr_n(clr_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .start(start),
    .frame_bits(frame_bits), .abort(abort), .din(din), .din_valid(din_valid),
    .busy(busy), .match(match), .match_count(match_count), .sat(sat),
    .done(done), .err(err)
  );

  seq_detect_ctrl #(.PAT_MAX(PAT_MAX), .CNT_W(2), .LEN_W(LEN_W)) dut_s (
    .clk(clk), .clr_n(clr_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .start(start),
    .frame_bits(frame_bits), .abort(abort), .din(din), .din_valid(din_valid),
    .busy(busy_s), .match(match_s), .match_count(match_count_s), .sat(sat_s),
    .done(done_s), .err(err_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    start = 1'b0; frame_bits = '0; abort = 1'b0; din = 1'b0; din_valid = 1'b0;
  endtask

  task automatic send(input logic b, input logic v);
    din = b; din_valid = v;
    cycle();
    din = 1'b0; din_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    clr_n = 1'b0;
    cycle(); cycle();
    n_checks++;
    if ({busy, match, match_count, sat, done, err} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b match=%b cnt=%0d sat=%b done=%b err=%b, want all 0",
               busy, match, match_count, sat, done, err);
    end
    clr_n = 1'b1;
    cycle();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: busy=%b want 0", busy);
    end
  endtask

  // Default config 1101/len4/overlap, stream 1101101101 -> matches at 4,7,10.
  task automatic test_overlap();
    logic [9:0] bits;
    logic [9:0] exp_m;
    int exp_cnt;
    bits = 10'b1101101101; exp_m = 10'b0001001001; exp_cnt = 0;
    start = 1'b1; frame_bits = 16'd10;
    cycle();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL overlap_start_busy: busy=%b want 1", busy);
    end
    for (int i = 0; i < 10; i++) begin
      send(bits[9-i], 1'b1);
      if (exp_m[9-i]) exp_cnt++;
      n_checks++;
      if (match !== exp_m[9-i] || done !== (i == 9) || busy !== (i != 9) ||
          match_count !== 8'(exp_cnt)) begin
        n_fail++;
        $display("FAIL overlap_bit%0d: match=%b done=%b busy=%b cnt=%0d want match=%b done=%b busy=%b cnt=%0d",
                 i + 1, match, done, busy, match_count, exp_m[9-i], i == 9, i != 9, exp_cnt);
      end
    end
    cycle();
    n_checks++;
    if (done !== 1'b0 || match !== 1'b0 || busy !== 1'b0 || match_count !== 8'd3) begin
      n_fail++;
      $display("FAIL overlap_after: done=%b match=%b busy=%b cnt=%0d want 0 0 0 3",
               done, match, busy, match_count);
    end
  endtask

  // Pattern 11/len2, stream 1111: overlap 0 -> bits 2,4; overlap 1 -> bits 2,3,4.
  task automatic test_nonoverlap();
    logic [3:0] exp_m;
    for (int pass = 0; pass < 2; pass++) begin
      exp_m = (pass == 0) ? 4'b0101 : 4'b0111;
      // Load and start in the same cycle: start is validated on the new len.
      cfg_we = 1'b1; cfg_pattern = 8'b11; cfg_len = 4'd2; cfg_overlap = (pass == 1);
      start = 1'b1; frame_bits = 16'd4;
      cycle();
      cfg_we = 1'b0; start = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || match_count !== 8'd0 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL nonov%0d_start: busy=%b cnt=%0d err=%b want 1 0 0", pass, busy, match_count, err);
      end
      for (int i = 0; i < 4; i++) begin
        send(1'b1, 1'b1);
        n_checks++;
        if (match !== exp_m[3-i] || done !== (i == 3)) begin
          n_fail++;
          $display("FAIL nonov%0d_bit%0d: match=%b done=%b want %b %b",
                   pass, i + 1, match, done, exp_m[3-i], i == 3);
        end
      end
      n_checks++;
      if (match_count !== ((pass == 0) ? 8'd2 : 8'd3)) begin
        n_fail++;
        $display("FAIL nonov%0d_count: cnt=%0d want %0d", pass, match_count, (pass == 0) ? 2 : 3);
      end
      cycle();
    end
  endtask

  // len 0, len 9 (> PAT_MAX), frame_bits 0: each pulses err once, count kept at 3.
  task automatic test_illegal();
    logic [LW-1:0]    lens   [3];
    logic [LEN_W-1:0] frames [3];
    lens = '{4'd0, 4'd9, 4'd2};
    frames = '{16'd5, 16'd5, 16'd0};
    for (int k = 0; k < 3; k++) begin
      cfg_we = 1'b1; cfg_pattern = 8'b11; cfg_len = lens[k]; cfg_overlap = 1'b1;
      start = 1'b1; frame_bits = frames[k];
      cycle();
      cfg_we = 1'b0; start = 1'b0;
      n_checks++;
      if (err !== 1'b1 || busy !== 1'b0 || match_count !== 8'd3) begin
        n_fail++;
        $display("FAIL illegal%0d_pulse: err=%b busy=%b cnt=%0d want 1 0 3", k, err, busy, match_count);
      end
      cycle();
      n_checks++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal%0d_after: err=%b busy=%b want 0 0", k, err, busy);
      end
    end
  endtask

  // Config left at 11/len2/overlap. Frame 3: bits 1,1 match; bit 3 with abort.
  task automatic test_abort();
    start = 1'b1; frame_bits = 16'd3;
    cycle();
    start = 1'b0;
    send(1'b1, 1'b1);
    send(1'b1, 1'b1);
    n_checks++;
    if (match !== 1'b1 || match_count !== 8'd1) begin
      n_fail++; $display("FAIL abort_pre_match: match=%b cnt=%0d want 1 1", match, match_count);
    end
    abort = 1'b1;
    send(1'b1, 1'b1);
    abort = 1'b0;
    n_checks++;
    if (match !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || match_count !== 8'd1) begin
      n_fail++;
      $display("FAIL abort_last: match=%b done=%b busy=%b cnt=%0d want 0 0 0 1",
               match, done, busy, match_count);
    end
    cycle();
    n_checks++;
    if (match !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || match_count !== 8'd1) begin
      n_fail++;
      $display("FAIL abort_after: match=%b done=%b busy=%b cnt=%0d want 0 0 0 1",
               match, done, busy, match_count);
    end
  endtask

  // Pattern 1/len1, 6 ones. CNT_W=2 instance: 1,2,3,3,3,3 and sat from bit 4.
  task automatic test_saturation();
    logic [1:0] exp_c [6];
    logic [5:0] exp_sat;
    exp_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    exp_sat = 6'b000111;
    cfg_we = 1'b1; cfg_pattern = 8'b1; cfg_len = 4'd1; cfg_overlap = 1'b1;
    start = 1'b1; frame_bits = 16'd6;
    cycle();
    cfg_we = 1'b0; start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(1'b1, 1'b1);
      n_checks++;
      if (match_s !== 1'b1 || match_count_s !== exp_c[i] || sat_s !== exp_sat[5-i] ||
          done_s !== (i == 5)) begin
        n_fail++;
        $display("FAIL sat_bit%0d: match=%b cnt=%0d sat=%b done=%b want 1 %0d %b %b",
                 i + 1, match_s, match_count_s, sat_s, done_s, exp_c[i], exp_sat[5-i], i == 5);
      end
    end
    n_checks++;
    if (match_count !== 8'd6 || sat !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_wide: cnt=%0d sat=%b done=%b want 6 0 1", match_count, sat, done);
    end
    cycle();
  endtask

  // Pattern 1101/len4 with din_valid gaps; cfg_we/start inside RUN and start
  // in DONE are ignored.
  task automatic test_gaps_ignored();
    cfg_we = 1'b1; cfg_pattern = 8'b1101; cfg_len = 4'd4; cfg_overlap = 1'b1;
    start = 1'b1; frame_bits = 16'd4;
    cycle();
    cfg_we = 1'b0; start = 1'b0;
    send(1'b1, 1'b1);
    // Gap carrying a config load and a start; a load would make 11/len2 hit next bit.
    cfg_we = 1'b1; cfg_pattern = 8'b11; cfg_len = 4'd2; start = 1'b1; frame_bits = 16'd2;
    send(1'b1, 1'b0);
    cfg_we = 1'b0; start = 1'b0;
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b1 || match !== 1'b0) begin
      n_fail++; $display("FAIL gap_ignored: err=%b busy=%b match=%b want 0 1 0", err, busy, match);
    end
    send(1'b1, 1'b1);
    n_checks++;
    if (match !== 1'b0) begin
      n_fail++; $display("FAIL gap_cfg_ignored: match=%b want 0", match);
    end
    send(1'b1, 1'b0);
    send(1'b0, 1'b1);
    send(1'b1, 1'b1);
    n_checks++;
    if (match !== 1'b1 || done !== 1'b1 || match_count !== 8'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_done: match=%b done=%b cnt=%0d busy=%b want 1 1 1 0",
               match, done, match_count, busy);
    end
    start = 1'b1; frame_bits = 16'd3;
    cycle();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL done_start_ignored: busy=%b err=%b done=%b want 0 0 0", busy, err, done);
    end
  endtask

  // Load 11/len2, match mid-run, reset asynchronously, then confirm that the
  // default config 1101/len4 is back (bit 2 must not match, bit 4 must).
  task automatic test_midrun_reset();
    logic [3:0] bits;
    logic [3:0] exp_m;
    bits = 4'b1101; exp_m = 4'b0001;
    cfg_we = 1'b1; cfg_pattern = 8'b11; cfg_len = 4'd2; cfg_overlap = 1'b1;
    start = 1'b1; frame_bits = 16'd8;
    cycle();
    cfg_we = 1'b0; start = 1'b0;
    send(1'b1, 1'b1);
    send(1'b1, 1'b1);
    n_checks++;
    if (match !== 1'b1 || busy !== 1'b1 || match_count !== 8'd1) begin
      n_fail++; $display("FAIL rst_pre: match=%b busy=%b cnt=%0d want 1 1 1", match, busy, match_count);
    end
    #2 clr_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, match, match_count, sat, done, err} !== 13'd0) begin
      n_fail++;
      $display("FAIL rst_async: busy=%b match=%b cnt=%0d sat=%b done=%b err=%b want all 0",
               busy, match, match_count, sat, done, err);
    end
    cycle();
    clr_n = 1'b1;
    cycle();
    start = 1'b1; frame_bits = 16'd4;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(bits[3-i], 1'b1);
      n_checks++;
      if (match !== exp_m[3-i]) begin
        n_fail++;
        $display("FAIL rst_default_cfg_bit%0d: match=%b want %b", i + 1, match, exp_m[3-i]);
      end
    end
    n_checks++;
    if (done !== 1'b1 || match_count !== 8'd1) begin
      n_fail++; $display("FAIL rst_default_done: done=%b cnt=%0d want 1 1", done, match_count);
    end
    cycle();
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_illegal();
    test_abort();
    test_saturation();
    test_gaps_ignored();
    test_midrun_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
